// File: rtl/tr_scan_ctrl.sv
// tr_scan_ctrl: loads TR columns one at a time and streams out the index of
// every set bit, lowest index first, with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start, emit_cnt holds the last session count
// LOAD  | col_ready high, waiting for the next column
// SCAN  | emitting set-bit addresses of the loaded column
// DONE  | one-cycle done pulse, then back to IDLE
module tr_scan_ctrl #(
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        col_valid_i,
  input  logic [ELEMENT_NUM-1:0]      col_data_i,
  input  logic                        col_last_i,
  output logic                        col_ready_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LOG2_ELEMENT_NUM-1:0] out_addr_o,
  output logic                        out_dup_o,
  output logic                        out_last_o,
  output logic [15:0]                 emit_cnt_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ELEMENT_NUM-1:0]   tr_q, tr_d;
  logic                     last_col_q, last_col_d;
  logic                     dup_q, dup_d;
  logic [15:0]              emit_cnt_q, emit_cnt_d;

  logic [ELEMENT_NUM-1:0]      tr_rest;
  logic [LOG2_ELEMENT_NUM-1:0] low_idx;
  logic                        scan_s;
  logic                        col_hs;
  logic                        out_hs;

  // Lowest set bit of TR; scanning downward lets bit 0 win.
  always_comb begin
    low_idx = '0;
    for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
      if (tr_q[i]) low_idx = LOG2_ELEMENT_NUM'(i);
    end
  end

  // TR with its lowest set bit cleared; zero means the emitted bit was the last.
  assign tr_rest = tr_q & (tr_q - ELEMENT_NUM'(1));

  assign scan_s = (state_q == SCAN);
  assign col_hs = col_valid_i & (state_q == LOAD);
  assign out_hs = scan_s & out_ready_i;

  assign col_ready_o = (state_q == LOAD);
  assign out_valid_o = scan_s;
  assign out_addr_o  = scan_s ? low_idx : '0;
  assign out_dup_o   = scan_s & dup_q;
  assign out_last_o  = scan_s & last_col_q & (tr_q != '0) & (tr_rest == '0);
  assign emit_cnt_o  = emit_cnt_q;
  assign busy_o      = (state_q == LOAD) | scan_s;
  assign done_o      = (state_q == DONE);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    tr_d       = tr_q;
    last_col_d = last_col_q;
    dup_d      = dup_q;
    emit_cnt_d = emit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = LOAD;
          emit_cnt_d = '0;
        end
      end
      LOAD: begin
        if (col_hs) begin
          tr_d       = col_data_i;
          last_col_d = col_last_i;
          dup_d      = 1'b0;
          if (col_data_i != '0) state_d = SCAN;
          else if (col_last_i)  state_d = DONE;
        end
      end
      SCAN: begin
        if (out_hs) begin
          tr_d       = tr_rest;
          dup_d      = 1'b1;
          emit_cnt_d = emit_cnt_q + 16'd1;
          if (tr_rest == '0) state_d = last_col_q ? DONE : LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tr_q       <= '0;
      last_col_q <= 1'b0;
      dup_q      <= 1'b0;
      emit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tr_q       <= tr_d;
      last_col_q <= last_col_d;
      dup_q      <= dup_d;
      emit_cnt_q <= emit_cnt_d;
    end
  end

endmodule

// File: tb/tb_tr_scan_ctrl.sv
// Directed bench for tr_scan_ctrl; expected values are hand-computed.
module tb_tr_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, col_valid, col_last, out_ready;
  logic [15:0] col_data;
  logic        col_ready, out_valid, out_dup, out_last, busy, done;
  logic [3:0]  out_addr;
  logic [15:0] emit_cnt;

  int checks = 0;
  int errors = 0;

  tr_scan_ctrl #(.ELEMENT_NUM(16), .LOG2_ELEMENT_NUM(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .col_valid_i(col_valid), .col_data_i(col_data), .col_last_i(col_last),
    .col_ready_o(col_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_dup_o(out_dup), .out_last_o(out_last),
    .emit_cnt_o(emit_cnt), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] a,
                           input logic d, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_addr"},  32'(out_addr),  32'(a));
    check({tag, "_dup"},   32'(out_dup),   32'(d));
    check({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_col(input logic [15:0] d, input logic l);
    col_valid = 1'b1;
    col_data  = d;
    col_last  = l;
    tick();
    col_valid = 1'b0;
    col_data  = '0;
    col_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; col_valid = 1'b0; col_data = '0;
    col_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_out("rst", 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst_col_ready", 32'(col_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_emit_cnt", 32'(emit_cnt), 32'd0);

    // 0x0012, last column, continuous ready
    start_session();
    check("s1_col_ready", 32'(col_ready), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
    check_out("s1_load", 1'b0, 4'd0, 1'b0, 1'b0);
    give_col(16'h0012, 1'b1);
    check_out("s1_a1", 1'b1, 4'd1, 1'b0, 1'b0);
    check("s1_col_ready_scan", 32'(col_ready), 32'd0);
    tick();
    check_out("s1_a4", 1'b1, 4'd4, 1'b1, 1'b1);
    check("s1_cnt_mid", 32'(emit_cnt), 32'd1);
    tick();
    check("s1_done", 32'(done), 32'd1);
    check("s1_valid_done", 32'(out_valid), 32'd0);
    check("s1_cnt", 32'(emit_cnt), 32'd2);
    tick();
    check("s1_done_drop", 32'(done), 32'd0);
    check("s1_busy_idle", 32'(busy), 32'd0);
    check("s1_cnt_hold", 32'(emit_cnt), 32'd2);

    // Zero column skipped, then 0x8000 last
    start_session();
    check("s2_cnt_clear", 32'(emit_cnt), 32'd0);
    give_col(16'h0000, 1'b0);
    check("s2_skip_ready", 32'(col_ready), 32'd1);
    check("s2_skip_valid", 32'(out_valid), 32'd0);
    give_col(16'h8000, 1'b1);
    check_out("s2_a15", 1'b1, 4'd15, 1'b0, 1'b1);
    tick();
    check("s2_done", 32'(done), 32'd1);
    check("s2_cnt", 32'(emit_cnt), 32'd1);
    tick();

    // 0x0009 with backpressure
    start_session();
    out_ready = 1'b0;
    give_col(16'h0009, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_out("s3_stall", 1'b1, 4'd0, 1'b0, 1'b0);
      tick();
    end
    check_out("s3_a0", 1'b1, 4'd0, 1'b0, 1'b0);
    check("s3_cnt_stall", 32'(emit_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    check_out("s3_a3", 1'b1, 4'd3, 1'b1, 1'b1);
    tick();
    check("s3_done", 32'(done), 32'd1);
    check("s3_cnt", 32'(emit_cnt), 32'd2);
    tick();

    // Full column
    start_session();
    give_col(16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check_out("s4_full", 1'b1, 4'(i), i != 0, i == 15);
      tick();
    end
    check("s4_done", 32'(done), 32'd1);
    check("s4_cnt", 32'(emit_cnt), 32'd16);
    tick();

    // Reset mid-scan of 0x00F0 after one accept
    start_session();
    give_col(16'h00F0, 1'b1);
    check_out("s5_a4", 1'b1, 4'd4, 1'b0, 1'b0);
    tick();
    check_out("s5_a5", 1'b1, 4'd5, 1'b1, 1'b0);
    check("s5_cnt1", 32'(emit_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("s5_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    check("s5_rst_cnt", 32'(emit_cnt), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_ready", 32'(col_ready), 32'd0);
    check("s5_rst_done", 32'(done), 32'd0);
    tick();
    check("s5_idle_hold", 32'(busy), 32'd0);
    start_session();
    give_col(16'h0012, 1'b1);
    check_out("s5_rerun_a1", 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    check_out("s5_rerun_a4", 1'b1, 4'd4, 1'b1, 1'b1);
    tick();
    check("s5_rerun_cnt", 32'(emit_cnt), 32'd2);
    tick();

    // col_valid in IDLE and start while busy are ignored
    give_col(16'hFFFF, 1'b1);
    check("s6_idle_busy", 32'(busy), 32'd0);
    check("s6_idle_valid", 32'(out_valid), 32'd0);
    check("s6_idle_cnt", 32'(emit_cnt), 32'd2);
    start_session();
    start = 1'b1;
    give_col(16'h0003, 1'b1);
    check_out("s6_a0", 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    check_out("s6_a1", 1'b1, 4'd1, 1'b1, 1'b1);
    check("s6_cnt_mid", 32'(emit_cnt), 32'd1);
    tick();
    check("s6_done", 32'(done), 32'd1);
    check("s6_cnt", 32'(emit_cnt), 32'd2);
    start = 1'b0;
    tick();
    check("s6_idle_after", 32'(busy), 32'd0);
    check("s6_cnt_hold", 32'(emit_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tr_scan_ctrl.md
TR_SCAN_CTRL -- requirements
Module: tr_scan_ctrl

Interface
REQ-001 Parameter ELEMENT_NUM, default 16, SHALL set the TR column width (one bit per element slot).
REQ-002 Parameter LOG2_ELEMENT_NUM, default 4, SHALL set the address width; ELEMENT_NUM == 2**LOG2_ELEMENT_NUM.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL begin a scan session when high in IDLE; ignored in every other state.
REQ-006 col_valid  in  1  SHALL mark col_data/col_last valid.
REQ-007 col_data  in  ELEMENT_NUM  SHALL carry one TR column; bit i set = element i matches the current value.
REQ-008 col_last  in  1  SHALL mark the final column of the session.
REQ-009 col_ready  out  1  SHALL be high only in LOAD.
REQ-010 out_valid  out  1  SHALL be high only in SCAN.
REQ-011 out_ready  in  1  SHALL be the downstream accept for out_addr.
REQ-012 out_addr  out  LOG2_ELEMENT_NUM  SHALL be the index of the lowest set bit of the TR register.
REQ-013 out_dup  out  1  SHALL be high when out_addr is not the first address emitted from the current column.
REQ-014 out_last  out  1  SHALL be high with out_valid on the final address of the col_last column.
REQ-015 emit_cnt  out  16  SHALL count accepted addresses in the session.
REQ-016 busy  out  1  SHALL be high in LOAD and SCAN.
REQ-017 done  out  1  SHALL pulse high for exactly one cycle in DONE.

Function
REQ-018 States SHALL be IDLE, LOAD, SCAN, DONE; encoding is free.
REQ-019 IDLE -> LOAD on start; emit_cnt SHALL clear to 0 on that same edge.
REQ-020 In LOAD, a column handshake (col_valid & col_ready) SHALL load col_data into TR, col_last into a last_col flag, and clear the first-of-column flag.
REQ-021 LOAD handshake with col_data == 0: col_last=0 -> stay in LOAD (column skipped, no output); col_last=1 -> DONE.
REQ-022 LOAD handshake with col_data != 0 SHALL go to SCAN; out_valid rises the following cycle (1-cycle latency).
REQ-023 In SCAN, out_addr SHALL be the lowest set bit index of TR (bit 0 highest priority); out_addr, out_dup, out_last SHALL hold stable while out_valid & ~out_ready.
REQ-024 On out_valid & out_ready, the emitted bit SHALL clear in TR, emit_cnt SHALL increment (wrapping modulo 2^16), and out_dup SHALL be high for all later addresses of that column.
REQ-025 If the cleared bit was the last set bit: last_col=0 -> LOAD; last_col=1 -> DONE; otherwise remain in SCAN, emitting one address per cycle under continuous out_ready.
REQ-026 out_last SHALL equal last_col & (TR has exactly one bit set) while out_valid.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; emit_cnt SHALL hold its value until the next start.
REQ-028 col_valid in any state other than LOAD SHALL be ignored (no handshake).
REQ-029 A full column (all ELEMENT_NUM bits set) SHALL emit addresses 0..ELEMENT_NUM-1 in order over ELEMENT_NUM accepted cycles.

Reset
REQ-030 On rst: state=IDLE, TR=0, last_col=0, emit_cnt=0, col_ready=0, out_valid=0, out_addr=0, out_dup=0, out_last=0, busy=0, done=0.
REQ-031 rst SHALL override all inputs, including in mid-SCAN or mid-LOAD; no output handshake may complete on the reset edge.

Verification
REQ-032 start; column 16'h0012 with col_last=1; out_ready=1 -> out_addr 1 (dup=0), then 4 (dup=1, last=1), done the next cycle, emit_cnt=2.
REQ-033 Columns 16'h0000 (last=0), 16'h8000 (last=1) -> zero column skipped, single output addr 15 with out_last=1, emit_cnt=1.
REQ-034 Column 16'h0009, out_ready low for 3 cycles -> out_addr=0 held stable with out_valid=1; after out_ready=1 -> addr 0 then 3.
REQ-035 Column 16'hFFFF with col_last=1 and continuous out_ready -> addrs 0..15 on 16 consecutive cycles, out_dup low only on addr 0, emit_cnt=16.
REQ-036 rst asserted during SCAN of 16'h00F0 after one accept -> next cycle all outputs at reset values, state IDLE; start re-runs cleanly.
REQ-037 start pulsed while busy, and col_valid high in IDLE -> no effect on state, TR or emit_cnt.
